// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the WB-stage pipeline write always wins the single
// RF port; long-latency results wait in a 2-entry age-ordered buffer and drain on idle cycles.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] ResultW,
    input  logic        LongValid,
    input  logic [4:0]  LongReg,
    input  logic [31:0] LongData,
    output logic        LongReady,
    output logic        RFWE,
    output logic [4:0]  RFWA,
    output logic [31:0] RFWD,
    output logic        StallReq,
    output logic [1:0]  Pending
);

    localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);

    // Buffer is kept compacted: entry 0 is always the oldest, entry 1 valid implies entry 0 valid.
    logic        entValid [2];
    logic [4:0]  entReg   [2];
    logic [31:0] entData  [2];

    logic        nxtValid [2];
    logic [4:0]  nxtReg   [2];
    logic [31:0] nxtData  [2];

    logic        keep     [2];
    logic        pipeActive;
    logic        drain;
    logic        enq;
    logic [3:0]  starveCnt;
    logic [3:0]  starveNxt;

    // Handshake: a long result transfers on a rising edge where LongValid and LongReady are both
    // high. LongReady comes from registered state only, so it never depends on LongValid.
    assign pipeActive = RegWriteW && (WriteRegW != 5'd0);
    assign Pending    = {1'b0, entValid[0]} + {1'b0, entValid[1]};
    assign LongReady  = !(entValid[0] && entValid[1]);
    assign drain      = !pipeActive && entValid[0];
    assign enq        = LongValid && LongReady && (LongReg != 5'd0)
                        && !(pipeActive && (LongReg == WriteRegW));

    always_comb begin
        keep[0] = entValid[0] && !drain && !(pipeActive && (entReg[0] == WriteRegW));
        keep[1] = entValid[1] && !(pipeActive && (entReg[1] == WriteRegW));
    end

    // Survivors slide toward entry 0 in age order; an accepted result lands behind them.
    always_comb begin
        nxtValid[0] = 1'b0;
        nxtValid[1] = 1'b0;
        nxtReg[0]   = entReg[0];
        nxtReg[1]   = entReg[1];
        nxtData[0]  = entData[0];
        nxtData[1]  = entData[1];
        if (keep[0]) begin
            nxtValid[0] = 1'b1;
            if (keep[1]) begin
                nxtValid[1] = 1'b1;
            end else if (enq) begin
                nxtValid[1] = 1'b1;
                nxtReg[1]   = LongReg;
                nxtData[1]  = LongData;
            end
        end else if (keep[1]) begin
            nxtValid[0] = 1'b1;
            nxtReg[0]   = entReg[1];
            nxtData[0]  = entData[1];
            if (enq) begin
                nxtValid[1] = 1'b1;
                nxtReg[1]   = LongReg;
                nxtData[1]  = LongData;
            end
        end else if (enq) begin
            nxtValid[0] = 1'b1;
            nxtReg[0]   = LongReg;
            nxtData[0]  = LongData;
        end
    end

    always_comb begin
        starveNxt = starveCnt;
        if (drain || (Pending == 2'd0)) begin
            starveNxt = 4'd0;
        end else if (starveCnt != 4'd15) begin
            starveNxt = starveCnt + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            entValid  <= '{default: 1'b0};
            entReg    <= '{default: 5'd0};
            entData   <= '{default: 32'd0};
            starveCnt <= 4'd0;
            StallReq  <= 1'b0;
        end else begin
            entValid  <= nxtValid;
            entReg    <= nxtReg;
            entData   <= nxtData;
            starveCnt <= starveNxt;
            StallReq  <= (starveCnt >= StarveLim);
        end
    end

    // Address/data hold their last value when the port is idle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RFWE <= 1'b0;
            RFWA <= 5'd0;
            RFWD <= 32'd0;
        end else if (pipeActive) begin
            RFWE <= 1'b1;
            RFWA <= WriteRegW;
            RFWD <= ResultW;
        end else if (drain) begin
            RFWE <= 1'b1;
            RFWA <= entReg[0];
            RFWD <= entData[0];
        end else begin
            RFWE <= 1'b0;
        end
    end

    compactBuf: assert property (@(posedge CLK) disable iff (!RST_N) entValid[1] |-> entValid[0]);
    noZeroReg:  assert property (@(posedge CLK) disable iff (!RST_N)
                                 entValid[0] |-> (entReg[0] != 5'd0));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic, every cycle compared
// against a queue-based model of the write-port sharing rules.
module tb_wb_port_arbiter;

    localparam int unsigned STARVE_LIMIT = 8;

    logic        CLK;
    logic        RST_N;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic        LongValid;
    logic [4:0]  LongReg;
    logic [31:0] LongData;
    logic        LongReady;
    logic        RFWE;
    logic [4:0]  RFWA;
    logic [31:0] RFWD;
    logic        StallReq;
    logic [1:0]  Pending;

    int errCnt = 0;
    int chkCnt = 0;

    // Reference state: buffered {reg,data} in age order, plus the expected port and stall.
    logic [36:0] expQ [$];
    int          mStarve;
    logic        mStall;
    logic        mWe;
    logic [4:0]  mWa;
    logic [31:0] mWd;
    logic        sawStale7;

    wb_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .LongValid(LongValid), .LongReg(LongReg), .LongData(LongData),
        .LongReady(LongReady),
        .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD),
        .StallReq(StallReq), .Pending(Pending)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1;
        if (RFWE && RFWA == 5'd7 && RFWD == 32'h11) sawStale7 = 1'b1;
    end

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        expQ.delete();
        mStarve = 0;
        mStall  = 1'b0;
        mWe     = 1'b0;
        mWa     = 5'd0;
        mWd     = 32'd0;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic stepCycle(input logic rw, input logic [4:0] wr, input logic [31:0] res,
                             input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        int   oldSize;
        logic pipe;
        logic rdy;
        logic drn;
        RegWriteW = rw;
        WriteRegW = wr;
        ResultW   = res;
        LongValid = lv;
        LongReg   = lr;
        LongData  = ld;
        #1;
        oldSize = expQ.size();
        checkEq("readyPre", LongReady, oldSize < 2);
        pipe = rw && (wr != 5'd0);
        rdy  = oldSize < 2;
        drn  = !pipe && oldSize > 0;
        mStall = (mStarve >= STARVE_LIMIT);
        if (drn || oldSize == 0) mStarve = 0;
        else if (mStarve < 15) mStarve++;
        if (pipe) begin
            mWe = 1'b1;
            mWa = wr;
            mWd = res;
            for (int i = expQ.size() - 1; i >= 0; i--)
                if (expQ[i][36:32] == wr) expQ.delete(i);
        end else if (drn) begin
            mWe = 1'b1;
            {mWa, mWd} = expQ.pop_front();
        end else begin
            mWe = 1'b0;
        end
        if (lv && rdy && lr != 5'd0 && !(pipe && lr == wr)) expQ.push_back({lr, ld});
        @(posedge CLK);
        #1;
        checkEq("rfwe", RFWE, mWe);
        checkEq("rfwa", RFWA, mWa);
        checkEq("rfwd", RFWD, mWd);
        checkEq("pending", Pending, expQ.size());
        checkEq("ready", LongReady, expQ.size() < 2);
        checkEq("stall", StallReq, mStall);
        @(negedge CLK);
    endtask

    task automatic idle();
        stepCycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic applyReset();
        RST_N = 1'b0;
        #1;
        modelReset();
        checkEq("rstRfwe", RFWE, 0);
        checkEq("rstRfwa", RFWA, 0);
        checkEq("rstRfwd", RFWD, 0);
        checkEq("rstStall", StallReq, 0);
        checkEq("rstPending", Pending, 0);
        checkEq("rstReady", LongReady, 1);
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        RegWriteW = 1'b0; WriteRegW = 5'd0; ResultW = 32'd0;
        LongValid = 1'b0; LongReg = 5'd0; LongData = 32'd0;
        sawStale7 = 1'b0;
        RST_N = 1'b1;
        @(negedge CLK);
        applyReset();

        // pipeline-only write, then a write to r0 which must not reach the port
        stepCycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        checkEq("pipeAddr", RFWA, 5'd5);
        checkEq("pipeData", RFWD, 32'h1234);
        stepCycle(1'b1, 5'd0, 32'hdead, 1'b0, 5'd0, 32'd0);
        checkEq("r0NoWrite", RFWE, 0);

        // idle drain of a single long result
        stepCycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'haa);
        idle();
        checkEq("drainAddr", RFWA, 5'd9);

        // fill while pipeline busy, third result ignored, drain in age order
        stepCycle(1'b1, 5'd1, 32'h100, 1'b1, 5'd3, 32'h333);
        stepCycle(1'b1, 5'd2, 32'h200, 1'b1, 5'd4, 32'h444);
        checkEq("fullReady", LongReady, 0);
        stepCycle(1'b1, 5'd1, 32'h101, 1'b1, 5'd5, 32'h555);
        idle();
        checkEq("firstDrain", RFWA, 5'd3);
        idle();
        checkEq("secondDrain", RFWA, 5'd4);
        idle();

        // WAW squash of a buffered entry
        sawStale7 = 1'b0;
        stepCycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h11);
        stepCycle(1'b1, 5'd1, 32'h2, 1'b1, 5'd8, 32'h22);
        stepCycle(1'b1, 5'd7, 32'h99, 1'b0, 5'd0, 32'd0);
        checkEq("squashPending", Pending, 1);
        idle();
        checkEq("squashDrain", RFWD, 32'h22);
        idle();
        idle();
        checkEq("noStale7", sawStale7, 0);

        // starvation builds StallReq, one idle cycle drains it away
        stepCycle(1'b1, 5'd1, 32'h5, 1'b1, 5'd2, 32'h77);
        for (int i = 0; i < 10; i++) stepCycle(1'b1, 5'd1, 32'(i), 1'b0, 5'd0, 32'd0);
        checkEq("stallSet", StallReq, 1);
        idle();
        idle();
        checkEq("stallClear", StallReq, 0);

        // asynchronous reset with a full, stalled buffer
        stepCycle(1'b1, 5'd1, 32'h5, 1'b1, 5'd2, 32'h71);
        stepCycle(1'b1, 5'd1, 32'h6, 1'b1, 5'd3, 32'h72);
        for (int i = 0; i < 10; i++) stepCycle(1'b1, 5'd1, 32'(i), 1'b0, 5'd0, 32'd0);
        checkEq("preRstPending", Pending, 2);
        checkEq("preRstStall", StallReq, 1);
        #2;
        applyReset();

        // random traffic on a small register range so squashes and r0 results are common
        for (int i = 0; i < 400; i++) begin
            stepCycle($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom(),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
            if (i % 50 == 49) begin
                for (int k = 0; k < 12; k++)
                    stepCycle(1'b1, 5'($urandom_range(1, 3)), $urandom(),
                              1'($urandom_range(0, 1)), 5'($urandom_range(4, 7)), $urandom());
            end
        end

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
